// File: rtl/wb_dest_pipe_pkg.sv
// Shared types and constants for the write-destination tracking pipeline.
package wb_dest_pipe_pkg;

  localparam int unsigned RW = 4;
  localparam logic [RW-1:0] NULL_TAG = 4'd0;

  // Load-use FSM encoding.
  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  // Forward-select codes used by the forwarding unit that consumes our tags.
  localparam logic [2:0] FWD_RF   = 3'b000;
  localparam logic [2:0] FWD_MEM1 = 3'b001;
  localparam logic [2:0] FWD_MEM2 = 3'b010;
  localparam logic [2:0] FWD_MEML = 3'b011;
  localparam logic [2:0] FWD_WB1  = 3'b100;
  localparam logic [2:0] FWD_WB2  = 3'b101;
  localparam logic [2:0] FWD_WBL  = 3'b110;

  // Contents of one pipeline slot.
  typedef struct packed {
    logic [RW-1:0] wr1;
    logic          wr1_en;
    logic [RW-1:0] wr2;
    logic          wr2_en;
    logic          ld;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // A tag is only meaningful when its enable is set; otherwise it reads as NULL_TAG.
  function automatic logic [RW-1:0] tag_of(input logic en, input logic [RW-1:0] r);
    return en ? r : NULL_TAG;
  endfunction

endpackage

// File: rtl/wb_dest_pipe_slot.sv
// One destination pipeline register: hold beats clear, clear beats load.
module dest_slot
  import wb_dest_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  clear,
  input  slot_t d,
  output slot_t q
);

  // Slot register: empty on reset, frozen on hold, bubble on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SLOT_EMPTY;
    end else if (!hold) begin
      if (clear) q <= SLOT_EMPTY;
      else       q <= d;
    end
  end

endmodule

// File: rtl/wb_dest_pipe.sv
// Tracks write destinations through EX/MEM/WB, drives forwarding tags and
// register-file write enables, and inserts one bubble on a load-use hazard.
// Handshake: there is no valid/ready pair here; ext_stall freezes every stage,
// and hz_stall asks upstream to hold its ID instruction for exactly one edge.
module wb_dest_pipe
  import wb_dest_pipe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] id_wr1,
  input  logic          id_wr1_en,
  input  logic [RW-1:0] id_wr2,
  input  logic          id_wr2_en,
  input  logic          id_wr2_ld,
  input  logic [RW-1:0] id_op1,
  input  logic [RW-1:0] id_op2,
  input  logic [RW-1:0] id_r15,
  input  logic          id_op1_use,
  input  logic          id_op2_use,
  input  logic          id_r15_use,
  input  logic          ext_stall,
  input  logic          flush,
  output logic [RW-1:0] memwrite1,
  output logic [RW-1:0] memwrite2,
  output logic [RW-1:0] wbwrite1,
  output logic [RW-1:0] wbwrite2,
  output logic          memmux,
  output logic          wbmux,
  output logic [RW-1:0] ex_wr1,
  output logic [RW-1:0] ex_wr2,
  output logic          rf_we1,
  output logic          rf_we2,
  output logic [RW-1:0] rf_wa1,
  output logic [RW-1:0] rf_wa2,
  output logic          hz_stall,
  output state_t        fsm_state
);

  slot_t  id_slot, ex_q, mem_q, wb_q;
  state_t state, state_next;
  logic   ex_clear;
  logic   load_in_ex;
  logic   src_hit;

  // Pack the ID-stage destination fields into a slot.
  always_comb begin
    id_slot        = SLOT_EMPTY;
    id_slot.wr1    = id_wr1;
    id_slot.wr1_en = id_wr1_en;
    id_slot.wr2    = id_wr2;
    id_slot.wr2_en = id_wr2_en;
    id_slot.ld     = id_wr2_ld;
  end

  // Load-use detection: a pending load in EX whose target an ID source reads.
  always_comb begin
    load_in_ex = ex_q.ld & ex_q.wr2_en;
    src_hit    = (ex_q.wr2 != NULL_TAG) &&
                 ((id_op1_use && (id_op1 == ex_q.wr2)) ||
                  (id_op2_use && (id_op2 == ex_q.wr2)) ||
                  (id_r15_use && (id_r15 == ex_q.wr2)));
    hz_stall   = (state == RUN) && load_in_ex && src_hit;
    // Both a flush and a hazard replace the ID capture with an empty slot.
    ex_clear   = flush | hz_stall;
  end

  dest_slot u_ex  (.clk(clk), .rst(rst), .hold(ext_stall), .clear(ex_clear), .d(id_slot), .q(ex_q));
  dest_slot u_mem (.clk(clk), .rst(rst), .hold(ext_stall), .clear(1'b0),     .d(ex_q),    .q(mem_q));
  dest_slot u_wb  (.clk(clk), .rst(rst), .hold(ext_stall), .clear(1'b0),     .d(mem_q),   .q(wb_q));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // FSM next state: a bubble lasts exactly one non-frozen edge; flush suppresses it.
  always_comb begin
    state_next = state;
    if (!ext_stall) begin
      case (state)
        RUN:     if (hz_stall && !flush) state_next = BUBBLE;
        BUBBLE:  state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  // Tag and select outputs derived from slot contents.
  always_comb begin
    ex_wr1    = tag_of(ex_q.wr1_en,  ex_q.wr1);
    ex_wr2    = tag_of(ex_q.wr2_en,  ex_q.wr2);
    memwrite1 = tag_of(mem_q.wr1_en, mem_q.wr1);
    memwrite2 = tag_of(mem_q.wr2_en, mem_q.wr2);
    wbwrite1  = tag_of(wb_q.wr1_en,  wb_q.wr1);
    wbwrite2  = tag_of(wb_q.wr2_en,  wb_q.wr2);
    memmux    = mem_q.ld & mem_q.wr2_en;
    wbmux     = wb_q.ld & wb_q.wr2_en;
    rf_we1    = wb_q.wr1_en;
    rf_we2    = wb_q.wr2_en;
    rf_wa1    = wbwrite1;
    rf_wa2    = wbwrite2;
    fsm_state = state;
  end

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed bench for wb_dest_pipe with a WB-stage scoreboard.
module tb_wb_dest_pipe;
  import wb_dest_pipe_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_wr1, id_wr2, id_op1, id_op2, id_r15;
  logic          id_wr1_en, id_wr2_en, id_wr2_ld;
  logic          id_op1_use, id_op2_use, id_r15_use;
  logic          ext_stall, flush;
  logic [RW-1:0] memwrite1, memwrite2, wbwrite1, wbwrite2, ex_wr1, ex_wr2, rf_wa1, rf_wa2;
  logic          memmux, wbmux, rf_we1, rf_we2, hz_stall;
  state_t        fsm_state;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected WB result: {rf_wa1, rf_we1, rf_wa2, rf_we2, wbmux}
  logic [10:0] exp_q[$];

  wb_dest_pipe dut (
    .clk(clk), .rst(rst),
    .id_wr1(id_wr1), .id_wr1_en(id_wr1_en), .id_wr2(id_wr2), .id_wr2_en(id_wr2_en),
    .id_wr2_ld(id_wr2_ld), .id_op1(id_op1), .id_op2(id_op2), .id_r15(id_r15),
    .id_op1_use(id_op1_use), .id_op2_use(id_op2_use), .id_r15_use(id_r15_use),
    .ext_stall(ext_stall), .flush(flush),
    .memwrite1(memwrite1), .memwrite2(memwrite2), .wbwrite1(wbwrite1), .wbwrite2(wbwrite2),
    .memmux(memmux), .wbmux(wbmux), .ex_wr1(ex_wr1), .ex_wr2(ex_wr2),
    .rf_we1(rf_we1), .rf_we2(rf_we2), .rf_wa1(rf_wa1), .rf_wa2(rf_wa2),
    .hz_stall(hz_stall), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic [RW-1:0] w1, input logic e1, input logic [RW-1:0] w2,
                        input logic e2, input logic ld);
    id_wr1 = w1; id_wr1_en = e1; id_wr2 = w2; id_wr2_en = e2; id_wr2_ld = ld;
  endtask

  task automatic set_src(input logic [RW-1:0] a, input logic au, input logic [RW-1:0] b,
                         input logic bu, input logic [RW-1:0] c, input logic cu);
    id_op1 = a; id_op1_use = au; id_op2 = b; id_op2_use = bu; id_r15 = c; id_r15_use = cu;
  endtask

  task automatic nop();
    set_id('0, 1'b0, '0, 1'b0, 1'b0);
    set_src('0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic push_exp(input logic [RW-1:0] w1, input logic e1, input logic [RW-1:0] w2,
                          input logic e2, input logic ld);
    logic [RW-1:0] t1, t2;
    t1 = e1 ? w1 : NULL_TAG;
    t2 = e2 ? w2 : NULL_TAG;
    exp_q.push_back({t1, e1, t2, e2, ld & e2});
  endtask

  // One clock; a freshly loaded, enabled WB slot is matched against the scoreboard.
  task automatic tick();
    logic frozen;
    frozen = ext_stall | rst;
    @(posedge clk);
    #1;
    if (!frozen && (rf_we1 || rf_we2)) begin
      if (exp_q.size() == 0) check("wb_unexpected", {rf_wa1, rf_we1, rf_wa2, rf_we2, wbmux}, 0);
      else check("wb_sb", {21'd0, rf_wa1, rf_we1, rf_wa2, rf_we2, wbmux}, {21'd0, exp_q.pop_front()});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tags"}, {memwrite1, memwrite2, wbwrite1, wbwrite2, ex_wr1, ex_wr2, rf_wa1, rf_wa2}, 0);
    check({tag, "_flags"}, {memmux, wbmux, rf_we1, rf_we2, hz_stall}, 0);
    check({tag, "_state"}, fsm_state, RUN);
  endtask

  initial begin
    rst = 1'b1; ext_stall = 1'b0; flush = 1'b0;
    nop();
    #12;
    check_all_zero("reset");
    rst = 1'b0;
    #1;

    // 1: single enabled wr1 walks EX -> MEM -> WB
    set_id(4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
    push_exp(4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
    tick(); check("t1_ex_wr1", ex_wr1, 5);
    nop();
    tick(); check("t1_mem_wr1", memwrite1, 5); check("t1_ex_wr1_empty", ex_wr1, 0);
    tick(); check("t1_wb", {wbwrite1, rf_we1, rf_wa1}, {4'd5, 1'b1, 4'd5});
    check("t1_others", {memwrite1, memwrite2, wbwrite2, rf_we2}, 0);

    // Both ports on the same register, then a disabled port with a nonzero index
    set_id(4'd8, 1'b1, 4'd8, 1'b1, 1'b0); push_exp(4'd8, 1'b1, 4'd8, 1'b1, 1'b0);
    tick();
    set_id(4'd12, 1'b0, 4'd13, 1'b1, 1'b0); push_exp(4'd12, 1'b0, 4'd13, 1'b1, 1'b0);
    tick(); check("dis_ex_wr1", ex_wr1, 0); check("dis_ex_wr2", ex_wr2, 13);
    nop();
    repeat (3) tick();

    // 2: load-use hazard inserts exactly one bubble
    set_id(4'd0, 1'b0, 4'd7, 1'b1, 1'b1); push_exp(4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    tick(); check("t2_ex_wr2", ex_wr2, 7);
    set_id(4'd3, 1'b1, 4'd0, 1'b0, 1'b0); set_src(4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    #1; check("t2_hz", hz_stall, 1);
    tick();
    check("t2_state", fsm_state, BUBBLE);
    check("t2_ex_empty", {ex_wr1, ex_wr2}, 0);
    check("t2_mem", {memwrite2, memmux}, {4'd7, 1'b1});
    check("t2_hz_once", hz_stall, 0);
    push_exp(4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    check("t2_state_run", fsm_state, RUN);
    check("t2_ex_cap", ex_wr1, 3);
    check("t2_wbmux", {wbwrite2, wbmux}, {4'd7, 1'b1});
    nop();
    repeat (3) tick();

    // 3: source match with use bit clear is not a hazard
    set_id(4'd0, 1'b0, 4'd7, 1'b1, 1'b1); push_exp(4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    tick();
    set_id(4'd4, 1'b1, 4'd0, 1'b0, 1'b0); set_src(4'd0, 1'b0, 4'd7, 1'b0, 4'd7, 1'b0);
    push_exp(4'd4, 1'b1, 4'd0, 1'b0, 1'b0);
    #1; check("t3_hz", hz_stall, 0);
    tick(); check("t3_ex", ex_wr1, 4); check("t3_state", fsm_state, RUN);
    nop();
    repeat (3) tick();

    // 4: flush wins over the hazard
    set_id(4'd0, 1'b0, 4'd7, 1'b1, 1'b1); push_exp(4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    tick();
    set_id(4'd6, 1'b1, 4'd0, 1'b0, 1'b0); set_src(4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    flush = 1'b1;
    tick();
    check("t4_state", fsm_state, RUN);
    check("t4_ex_empty", {ex_wr1, ex_wr2}, 0);
    check("t4_mem", memwrite2, 7);
    flush = 1'b0; nop();
    repeat (3) tick();

    // 5: ext_stall freezes everything
    set_id(4'd9, 1'b1, 4'd0, 1'b0, 1'b0); push_exp(4'd9, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    set_id(4'd10, 1'b1, 4'd0, 1'b0, 1'b0); push_exp(4'd10, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    nop();
    tick(); check("t5_wb_pre", wbwrite1, 9);
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_wb", {wbwrite1, rf_we1}, {4'd9, 1'b1});
      check("t5_hold_mem", memwrite1, 10);
    end
    ext_stall = 1'b0;
    tick(); check("t5_adv", wbwrite1, 10);
    repeat (2) tick();

    // 6: asynchronous reset in the middle of a bubble
    set_id(4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    tick();
    set_id(4'd2, 1'b1, 4'd0, 1'b0, 1'b0); set_src(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1);
    #1; check("t6_hz_r15", hz_stall, 1);
    tick(); check("t6_bubble", fsm_state, BUBBLE);
    #2; rst = 1'b1;
    #1; check_all_zero("t6_async");
    exp_q.delete();
    nop();
    #1; rst = 1'b0;
    repeat (4) tick();

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_dest_pipe.md
Name: wb_dest_pipe

Overview:
- Tracks register write destinations for the instruction flow ID -> EX -> MEM -> WB.
- Drives the memwrite1/memwrite2/wbwrite1/wbwrite2 tags and memmux/wbmux source selects consumed by the register-forwarding unit, plus the register-file write enables at WB.
- Detects load-use hazards between ID and EX, stalls ID/IF for one cycle and injects a bubble into EX.

Parameters:
- RW, 4, register index width (16 architectural registers).
- NULL_TAG, 4'd0, tag driven by an empty or invalid slot. R0 is never a write target, so a NULL_TAG tag never produces a false forward.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_wr1  in  RW  destination of write port 1 for the instruction in ID.
- id_wr1_en  in  1  ID instruction writes port 1.
- id_wr2  in  RW  destination of write port 2 for the instruction in ID.
- id_wr2_en  in  1  ID instruction writes port 2.
- id_wr2_ld  in  1  port-2 data is load data (memory source).
- id_op1, id_op2, id_r15  in  RW each  source registers read by the ID instruction.
- id_op1_use, id_op2_use, id_r15_use  in  1 each  corresponding source is actually read.
- ext_stall  in  1  stall from outside (e.g. memory wait); freezes all stages.
- flush  in  1  branch taken; kills the ID and EX slots.
- memwrite1, memwrite2  out  RW  MEM-stage destination tags.
- wbwrite1, wbwrite2  out  RW  WB-stage destination tags.
- memmux, wbmux  out  1  port-2 source is load data, at MEM and WB respectively.
- ex_wr1, ex_wr2  out  RW  EX-stage destination tags.
- rf_we1, rf_we2  out  1  register-file write enables (WB slot valid and enabled).
- rf_wa1, rf_wa2  out  RW  register-file write addresses (equal to the WB tags).
- hz_stall  out  1  load-use stall request to the PC and IF/ID registers.

Behaviour:
- Three slots (EX, MEM, WB). Each slot holds: wr1, wr1_en, wr2, wr2_en, ld.
- A tag output is the slot's wrN when wrN_en = 1; otherwise it is NULL_TAG.
- memmux = MEM.ld & MEM.wr2_en; wbmux = WB.ld & WB.wr2_en.
- Reset (asynchronous, any time, including mid-stall):
  - all slots empty;
  - all tag outputs = NULL_TAG;
  - memmux = wbmux = 0, rf_we1 = rf_we2 = 0, hz_stall = 0;
  - state = RUN.
- Normal advance, each clock when not frozen: WB <= MEM, MEM <= EX, EX <= ID inputs. Latency from ID capture to the WB tags is 3 cycles.
- hz_stall is combinational. It is 1 when state = RUN, the EX slot has ld = 1 and wr2_en = 1, and ex_wr2 equals any source with its _use bit set among id_op1/id_op2/id_r15. A match on NULL_TAG is ignored.
- FSM, two states:
  - RUN -> BUBBLE when hz_stall = 1 and ext_stall = 0. On that edge EX <= empty (bubble); MEM and WB advance; the ID instruction is held upstream.
  - BUBBLE -> RUN unconditionally on the next non-frozen edge. The load is now in MEM, and forwarding uses memmux=1.
  - hz_stall is forced to 0 in BUBBLE, so two back-to-back hazards are not double-counted.
- ext_stall = 1: all slots and FSM state hold. rf_we stays at its current value; the register file must tolerate rewriting the same value.
- flush = 1 (not frozen): EX <= empty and the ID capture is discarded; MEM and WB advance normally.
- Simultaneous events, in priority order:
  - rst > ext_stall > flush > hz_stall.
  - flush with hz_stall: the flush wins, no bubble is counted, and the FSM stays in RUN.
- Port 1 and port 2 may target the same register; both enables are asserted, and the register file gives port 2 priority.
- wrN_en = 0 with a non-zero wrN: the slot still drives NULL_TAG.

Decomposition:
- Shared package: RW, NULL_TAG, FSM state encoding (RUN = 1'b0, BUBBLE = 1'b1), and the forward-select code constants used by the forwarding unit (3'b000 to 3'b110).
- One natural sub-module, dest_slot: a single pipeline register with hold/clear/load controls, instantiated three times.

Test Plan:
1. Reset release, then ID wr1 = 5 (enabled) for 1 cycle -> ex_wr1 = 5 at +1, memwrite1 = 5 at +2, wbwrite1 = 5 with rf_we1 = 1 and rf_wa1 = 5 at +3; all other tags = 0.
2. Load to r7 in EX (wr2_en = 1, ld = 1), ID reads op1 = 7 -> hz_stall = 1 for exactly one cycle; the next cycle has an empty EX, memwrite2 = 7 and memmux = 1; wbmux = 1 one cycle later.
3. Load r7 in EX, ID reads op2 = 7 with id_op2_use = 0 -> hz_stall stays 0 and no bubble is inserted.
4. Same hazard as case 2 with flush asserted in the same cycle -> hz_stall ignored, EX empty, FSM remains RUN, memwrite2 = 7 at the next edge.
5. ext_stall held 3 cycles with wb slot wr1 = 9 -> wbwrite1 stays 9 and rf_we1 stays 1 throughout; slots advance once ext_stall drops.
6. rst asserted asynchronously mid-BUBBLE -> all outputs drop to 0 / NULL_TAG before the next clock edge; the FSM returns to RUN.
